// File: rtl/pulse_duty_shaper.sv
// pulse_duty_shaper: regenerates a near-50% duty clk_out from a one-cycle divider strobe
//   clk, rst_n   : clock, asynchronous active-low reset
//   en           : enable; low returns the block to IDLE on the next cycle
//   pulse_in     : one-cycle strobe arriving every N or N+1 cycles
//   clk_out      : registered waveform, high for max(1, I>>1) cycles after each strobe
//   interval_q   : last measured strobe-to-strobe interval
//   locked       : high once a full interval has been measured
//   err_short    : one-cycle flag, interval below MIN_INTERVAL
//   err_timeout  : one-cycle flag, gap counter saturated without a strobe
module pulse_duty_shaper #(
   parameter int CNT_W        = 8,
   parameter int MIN_INTERVAL = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             pulse_in,
   output logic             clk_out,
   output logic [CNT_W-1:0] interval_q,
   output logic             locked,
   output logic             err_short,
   output logic             err_timeout
);
   typedef enum logic [1:0] {IDLE, MEASURE, RUN} state_t;
   localparam logic [CNT_W-1:0] GAP_MAX = {CNT_W{1'b1}};
   state_t           state;
   logic [CNT_W-1:0] gap_cnt;
   logic [CNT_W-1:0] high_rem;
   logic [CNT_W:0]   ival;
   logic [CNT_W-1:0] half;
   logic [CNT_W-1:0] high_m1;
   logic             short_iv;
   // interval is one wider than the counter so a strobe in the saturating cycle reads 2^CNT_W
   always_comb begin
      ival     = (CNT_W+1)'(gap_cnt) + (CNT_W+1)'(1);
      half     = ival[CNT_W:1];
      high_m1  = (half == '0) ? '0 : half - 1'b1;
      short_iv = ival < (CNT_W+1)'(MIN_INTERVAL);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         gap_cnt     <= '0;
         high_rem    <= '0;
         clk_out     <= 1'b0;
         interval_q  <= '0;
         locked      <= 1'b0;
         err_short   <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         err_short   <= 1'b0;
         err_timeout <= 1'b0;
         gap_cnt     <= pulse_in ? '0 : (gap_cnt == GAP_MAX) ? gap_cnt : gap_cnt + 1'b1;
         if (!en) begin
            state      <= IDLE;
            gap_cnt    <= '0;
            high_rem   <= '0;
            clk_out    <= 1'b0;
            interval_q <= '0;
            locked     <= 1'b0;
         end else if (state == IDLE) begin
            if (pulse_in) state <= MEASURE;
         end else if (pulse_in) begin
            // a strobe wins over high-phase expiry, so a shrinking interval never glitches low
            state      <= RUN;
            interval_q <= ival[CNT_W-1:0];
            locked     <= 1'b1;
            clk_out    <= 1'b1;
            high_rem   <= high_m1;
            err_short  <= short_iv;
         end else if (gap_cnt == GAP_MAX) begin
            state       <= IDLE;
            high_rem    <= '0;
            clk_out     <= 1'b0;
            interval_q  <= '0;
            locked      <= 1'b0;
            err_timeout <= 1'b1;
         end else if (high_rem != '0) begin
            high_rem <= high_rem - 1'b1;
         end else begin
            clk_out <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_pulse_duty_shaper.sv
// tb_pulse_duty_shaper: directed self-checking bench for pulse_duty_shaper
module tb_pulse_duty_shaper;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       pulse_in = 1'b0;
   logic       clk_out;
   logic [7:0] interval_q;
   logic       locked;
   logic       err_short;
   logic       err_timeout;
   int         checks = 0;
   int         errors = 0;
   int         rises = 0;
   logic       prev_clk = 1'b0;
   pulse_duty_shaper #(.CNT_W(8), .MIN_INTERVAL(2)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .pulse_in(pulse_in),
      .clk_out(clk_out), .interval_q(interval_q), .locked(locked),
      .err_short(err_short), .err_timeout(err_timeout)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask
   task automatic step(input logic p);
      pulse_in = p;
      @(posedge clk);
      #1;
   endtask
   // one strobe followed by iv-1 quiet cycles; exp_q is the interval the strobe closes
   task automatic period(input int iv, input int exp_q, input int exp_h);
      for (int k = 0; k < iv; k++) begin
         step(k == 0);
         if (k == 0) begin
            chk("iv_q", interval_q, exp_q);
            chk("short", err_short, exp_q < 2);
            chk("lock", locked, 1);
         end
         if (k == 1) chk("short_clr", err_short, 0);
         chk("clk", clk_out, k < exp_h);
         if (clk_out && !prev_clk) rises++;
         prev_clk = clk_out;
      end
   endtask
   initial begin
      int frac[10] = '{9, 9, 8, 9, 9, 8, 9, 9, 9, 8};
      int prev;
      int n;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_all", {clk_out, locked, err_short, err_timeout, interval_q}, 0);
      rst_n = 1'b1;
      en = 1'b1;
      for (int i = 0; i < 100; i++) begin
         step(0);
         chk("idle_quiet", {clk_out, locked, err_short, err_timeout}, 0);
      end
      step(1);
      chk("meas_unlocked", locked, 0);
      repeat (7) step(0);
      for (int i = 0; i < 4; i++) period(8, 8, 4);
      prev = 8;
      rises = 0;
      for (int i = 0; i < 10; i++) begin
         period(frac[i], prev, prev / 2);
         prev = frac[i];
      end
      chk("frac_rises", rises, 10);
      period(1, 8, 4);
      period(8, 1, 1);
      period(8, 8, 4);
      step(1);
      n = 0;
      while (!err_timeout && n < 300) begin
         step(0);
         n++;
      end
      chk("to_cycles", n, 256);
      chk("to_state", {clk_out, locked, interval_q}, 0);
      step(0);
      chk("to_single", err_timeout, 0);
      step(1);
      chk("relock_meas", locked, 0);
      repeat (7) step(0);
      period(8, 8, 4);
      step(1);
      chk("en_hi", clk_out, 1);
      step(0);
      en = 1'b0;
      step(1);
      chk("en_off", {clk_out, locked, interval_q}, 0);
      en = 1'b1;
      step(1);
      chk("en_first", {clk_out, locked}, 0);
      repeat (7) step(0);
      period(8, 8, 4);
      step(1);
      step(1);
      chk("pre_rst_short", err_short, 1);
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst", {clk_out, locked, err_short, err_timeout, interval_q}, 0);
      #4 rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(0);
         chk("post_rst", {clk_out, locked, err_short, err_timeout}, 0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
